// File: rtl/hist_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hist_pkg
// Description : Shared types and elaboration-time helpers for the per-pixel
//               histogram / peak builder (state encoding, index widths,
//               frame slot count, TDC-code-to-bin mapping).
// Revision    : 1.0 - initial release
// ============================================================================
package hist_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // Number of coarse bins for a given bin index width.
  function automatic int bin_num(input int bin_w);
    return 1 << bin_w;
  endfunction

  // Index width for a counter over n items; never below one bit so that
  // single-item configurations still produce a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Total code slots in one frame.
  function automatic int frame_slots(input int acq_num, input int pixel_num,
                                     input int data_num);
    return acq_num * pixel_num * data_num;
  endfunction

  // Coarse bin of a TDC code: its top bin_w bits.
  function automatic logic [31:0] bin_of(input logic [31:0] code,
                                         input int tdc_w, input int bin_w);
    return code >> (tdc_w - bin_w);
  endfunction

endpackage : hist_pkg
`default_nettype wire

// File: rtl/hist_peak_scan.sv
`default_nettype none
// ============================================================================
// Module      : hist_peak_scan
// Description : Running argmax over a histogram presented one bin per cycle.
//               Strict greater-than comparison, so the lowest bin wins ties.
//               peak_bin/peak_cnt already include the bin on the current
//               cycle, letting the caller capture the final result on the
//               same cycle the last bin is read.
// Ports       : clk, res (async, active high), clr (sync abort)
//               en       - a bin is presented this cycle
//               start    - first bin of a histogram (discards previous max)
//               bin_idx  - index of the presented bin
//               bin_cnt  - count of the presented bin
//               peak_bin - argmax including the presented bin
//               peak_cnt - max count including the presented bin
//               rd_clr   - strobe: presented bin has been consumed, clear it
// Revision    : 1.0 - initial release
// ============================================================================
module hist_peak_scan #(
  parameter int BIN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             en,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_idx,
  input  logic [CNT_W-1:0] bin_cnt,
  output logic [BIN_W-1:0] peak_bin,
  output logic [CNT_W-1:0] peak_cnt,
  output logic             rd_clr
);

  logic [BIN_W-1:0] max_bin_q, max_bin_d;
  logic [CNT_W-1:0] max_cnt_q, max_cnt_d;
  logic             take;

  always_comb begin
    // On start the previous histogram's max is ignored, so bin 0 is always
    // taken; an all-zero histogram therefore reports bin 0, count 0.
    take      = start || (bin_cnt > max_cnt_q);
    peak_bin  = take ? bin_idx : max_bin_q;
    peak_cnt  = take ? bin_cnt : max_cnt_q;
    max_bin_d = max_bin_q;
    max_cnt_d = max_cnt_q;
    if (clr) begin
      max_bin_d = '0;
      max_cnt_d = '0;
    end else if (en) begin
      max_bin_d = peak_bin;
      max_cnt_d = peak_cnt;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      max_bin_q <= '0;
      max_cnt_q <= '0;
    end else begin
      max_bin_q <= max_bin_d;
      max_cnt_q <= max_cnt_d;
    end
  end

  assign rd_clr = en;

endmodule : hist_peak_scan
`default_nettype wire

// File: rtl/hist_peak_builder.sv
`default_nettype none
// ============================================================================
// Module      : hist_peak_builder
// Description : Builds one saturating coarse-bin histogram per pixel from a
//               stream of TDC codes in acquisition/pixel/sample order, then
//               scans each histogram (clearing it as it is read) and emits one
//               peak record per pixel over valid/ready.
// Ports       : clk, res (async, active high), clr (sync frame abort)
//               in_valid/in_ready/in_data  - TDC code stream, 0 = no photon
//               pk_valid/pk_ready          - peak record handshake
//               pk_pixel/pk_bin/pk_count   - peak record fields
//               pk_hit                     - pk_count >= MIN_PEAK
//               frame_done                 - asserted with the handshake of
//                                            the last pixel's record
// Revision    : 1.0 - initial release
// ============================================================================
module hist_peak_builder
  import hist_pkg::*;
#(
  parameter int TDC_W     = 10,
  parameter int BIN_W     = 4,
  parameter int CNT_W     = 8,
  parameter int PIXEL_NUM = 3,
  parameter int DATA_NUM  = 2,
  parameter int ACQ_NUM   = 3,
  parameter int MIN_PEAK  = 2
) (
  input  logic                             clk,
  input  logic                             res,
  input  logic                             clr,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [TDC_W-1:0]                 in_data,
  output logic                             pk_valid,
  input  logic                             pk_ready,
  output logic [idx_w(PIXEL_NUM)-1:0]      pk_pixel,
  output logic [BIN_W-1:0]                 pk_bin,
  output logic [CNT_W-1:0]                 pk_count,
  output logic                             pk_hit,
  output logic                             frame_done
);

  localparam int          BIN_NUM  = bin_num(BIN_W);
  localparam int          PIX_W    = idx_w(PIXEL_NUM);
  localparam int          SMP_W    = idx_w(DATA_NUM);
  localparam int          ACQ_W    = idx_w(ACQ_NUM);
  localparam int unsigned MIN_U    = MIN_PEAK;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hist_q [PIXEL_NUM][BIN_NUM];
  logic [CNT_W-1:0] hist_d [PIXEL_NUM][BIN_NUM];
  logic [SMP_W-1:0] smp_q, smp_d;
  logic [PIX_W-1:0] pix_q, pix_d;     // input pixel in ACCUM, scan pointer after
  logic [ACQ_W-1:0] acq_q, acq_d;
  logic [BIN_W-1:0] bin_idx_q, bin_idx_d;
  logic             in_ready_q, in_ready_d;
  logic             pk_valid_q, pk_valid_d;
  logic [PIX_W-1:0] pk_pixel_q, pk_pixel_d;
  logic [BIN_W-1:0] pk_bin_q, pk_bin_d;
  logic [CNT_W-1:0] pk_count_q, pk_count_d;
  logic             pk_hit_q, pk_hit_d;

  logic             accept;
  logic             hshake;
  logic             last_smp, last_pix, last_acq;
  logic [BIN_W-1:0] code_bin;
  logic             scan_en;
  logic [BIN_W-1:0] scan_bin;
  logic [CNT_W-1:0] scan_cnt;
  logic             scan_rd_clr;

  assign accept   = in_valid && in_ready_q;
  assign hshake   = pk_valid_q && pk_ready;
  assign last_smp = (smp_q == SMP_W'(DATA_NUM - 1));
  assign last_pix = (pix_q == PIX_W'(PIXEL_NUM - 1));
  assign last_acq = (acq_q == ACQ_W'(ACQ_NUM - 1));
  assign code_bin = BIN_W'(bin_of(32'(in_data), TDC_W, BIN_W));
  assign scan_en  = (state_q == ST_SCAN);

  hist_peak_scan #(
    .BIN_W (BIN_W),
    .CNT_W (CNT_W)
  ) u_scan (
    .clk      (clk),
    .res      (res),
    .clr      (clr),
    .en       (scan_en),
    .start    (bin_idx_q == '0),
    .bin_idx  (bin_idx_q),
    .bin_cnt  (hist_q[pix_q][bin_idx_q]),
    .peak_bin (scan_bin),
    .peak_cnt (scan_cnt),
    .rd_clr   (scan_rd_clr)
  );

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    smp_d      = smp_q;
    pix_d      = pix_q;
    acq_d      = acq_q;
    bin_idx_d  = bin_idx_q;
    pk_valid_d = pk_valid_q;
    pk_pixel_d = pk_pixel_q;
    pk_bin_d   = pk_bin_q;
    pk_count_d = pk_count_q;
    pk_hit_d   = pk_hit_q;

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          // Histogram write is a single-cycle register update, so
          // back-to-back hits on one bin both land.
          if ((in_data != '0) && (hist_q[pix_q][code_bin] != CNT_MAX)) begin
            hist_d[pix_q][code_bin] = hist_q[pix_q][code_bin] + CNT_W'(1);
          end
          smp_d = last_smp ? '0 : smp_q + SMP_W'(1);
          if (last_smp) begin
            pix_d = last_pix ? '0 : pix_q + PIX_W'(1);
            if (last_pix) begin
              acq_d = last_acq ? '0 : acq_q + ACQ_W'(1);
            end
          end
          // Counters wrap to zero here, which doubles as scan pointer = 0.
          if (last_smp && last_pix && last_acq) begin
            state_d   = ST_SCAN;
            bin_idx_d = '0;
          end
        end
      end

      ST_SCAN: begin
        if (scan_rd_clr) begin
          hist_d[pix_q][bin_idx_q] = '0;
        end
        bin_idx_d = bin_idx_q + BIN_W'(1);
        if (&bin_idx_q) begin
          state_d    = ST_OUT;
          pk_valid_d = 1'b1;
          pk_pixel_d = pix_q;
          pk_bin_d   = scan_bin;
          pk_count_d = scan_cnt;
          pk_hit_d   = (32'(scan_cnt) >= MIN_U);
        end
      end

      ST_OUT: begin
        if (hshake) begin
          pk_valid_d = 1'b0;
          bin_idx_d  = '0;
          if (!last_pix) begin
            pix_d   = pix_q + PIX_W'(1);
            state_d = ST_SCAN;
          end else begin
            pix_d   = '0;
            state_d = ST_ACCUM;
          end
        end
      end

      default: state_d = ST_ACCUM;
    endcase

    // Frame abort overrides every other update.
    if (clr) begin
      state_d    = ST_ACCUM;
      hist_d     = '{default: '0};
      smp_d      = '0;
      pix_d      = '0;
      acq_d      = '0;
      bin_idx_d  = '0;
      pk_valid_d = 1'b0;
      pk_pixel_d = '0;
      pk_bin_d   = '0;
      pk_count_d = '0;
      pk_hit_d   = 1'b0;
    end

    in_ready_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= ST_ACCUM;
      hist_q     <= '{default: '0};
      smp_q      <= '0;
      pix_q      <= '0;
      acq_q      <= '0;
      bin_idx_q  <= '0;
      in_ready_q <= 1'b0;
      pk_valid_q <= 1'b0;
      pk_pixel_q <= '0;
      pk_bin_q   <= '0;
      pk_count_q <= '0;
      pk_hit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      smp_q      <= smp_d;
      pix_q      <= pix_d;
      acq_q      <= acq_d;
      bin_idx_q  <= bin_idx_d;
      in_ready_q <= in_ready_d;
      pk_valid_q <= pk_valid_d;
      pk_pixel_q <= pk_pixel_d;
      pk_bin_q   <= pk_bin_d;
      pk_count_q <= pk_count_d;
      pk_hit_q   <= pk_hit_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign pk_valid   = pk_valid_q;
  assign pk_pixel   = pk_pixel_q;
  assign pk_bin     = pk_bin_q;
  assign pk_count   = pk_count_q;
  assign pk_hit     = pk_hit_q;
  assign frame_done = hshake && (pk_pixel_q == PIX_W'(PIXEL_NUM - 1));

endmodule : hist_peak_builder
`default_nettype wire

// File: tb/tb_hist_peak_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hist_peak_builder
// Description : Self-checking bench for hist_peak_builder. Two instances share
//               the stimulus: one with 8-bit counters and one with 2-bit
//               counters (saturation). Expected records come from a
//               frame-level histogram model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hist_peak_builder;

  localparam int TDC_W    = 10;
  localparam int BIN_W    = 4;
  localparam int CNT_W    = 8;
  localparam int SAT_W    = 2;
  localparam int P        = 2;
  localparam int D        = 2;
  localparam int A        = 3;
  localparam int MIN_PEAK = 2;
  localparam int BIN_NUM  = 1 << BIN_W;
  localparam int FRAME    = A * P * D;

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic [TDC_W-1:0] in_data = '0;
  logic             pk_ready = 1'b0;

  logic             in_ready, pk_valid, pk_hit, frame_done;
  logic [0:0]       pk_pixel;
  logic [BIN_W-1:0] pk_bin;
  logic [CNT_W-1:0] pk_count;

  logic             s_in_ready, s_pk_valid, s_pk_hit, s_frame_done;
  logic [0:0]       s_pk_pixel;
  logic [BIN_W-1:0] s_pk_bin;
  logic [SAT_W-1:0] s_pk_count;

  int n_cmp = 0;
  int n_bad = 0;

  int frame_codes [FRAME];
  int exp_bin [P];
  int exp_cnt [P];
  int sat_bin [P];
  int sat_cnt [P];

  always #5 clk = ~clk;

  hist_peak_builder #(
    .TDC_W(TDC_W), .BIN_W(BIN_W), .CNT_W(CNT_W), .PIXEL_NUM(P),
    .DATA_NUM(D), .ACQ_NUM(A), .MIN_PEAK(MIN_PEAK)
  ) u_dut (
    .clk(clk), .res(res), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .pk_valid(pk_valid), .pk_ready(pk_ready),
    .pk_pixel(pk_pixel), .pk_bin(pk_bin), .pk_count(pk_count),
    .pk_hit(pk_hit), .frame_done(frame_done)
  );

  hist_peak_builder #(
    .TDC_W(TDC_W), .BIN_W(BIN_W), .CNT_W(SAT_W), .PIXEL_NUM(P),
    .DATA_NUM(D), .ACQ_NUM(A), .MIN_PEAK(MIN_PEAK)
  ) u_sat (
    .clk(clk), .res(res), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .pk_valid(s_pk_valid), .pk_ready(pk_ready),
    .pk_pixel(s_pk_pixel), .pk_bin(s_pk_bin), .pk_count(s_pk_count),
    .pk_hit(s_pk_hit), .frame_done(s_frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Histogram each pixel over the whole frame, saturate at cmax, pick the
  // highest count with the lowest bin on ties.
  task automatic model(input int cmax, output int ob [P], output int oc [P]);
    int h [P][BIN_NUM];
    int pix;
    int b;
    for (int p = 0; p < P; p++)
      for (int k = 0; k < BIN_NUM; k++) h[p][k] = 0;
    for (int s = 0; s < FRAME; s++) begin
      pix = (s / D) % P;
      if (frame_codes[s] != 0) begin
        b = frame_codes[s] / (1 << (TDC_W - BIN_W));
        if (h[pix][b] < cmax) h[pix][b]++;
      end
    end
    for (int p = 0; p < P; p++) begin
      ob[p] = 0;
      oc[p] = h[p][0];
      for (int k = 1; k < BIN_NUM; k++)
        if (h[p][k] > oc[p]) begin
          ob[p] = k;
          oc[p] = h[p][k];
        end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_pk_valid"}, pk_valid, 0);
    check({tag, "_pk_pixel"}, pk_pixel, 0);
    check({tag, "_pk_bin"}, pk_bin, 0);
    check({tag, "_pk_count"}, pk_count, 0);
    check({tag, "_pk_hit"}, pk_hit, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic drive_code(input int code);
    int n;
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = TDC_W'(code);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_frame(input string tag, input int stall0);
    int n;
    int stall;
    model((1 << CNT_W) - 1, exp_bin, exp_cnt);
    model((1 << SAT_W) - 1, sat_bin, sat_cnt);
    check({tag, "_no_stale_record"}, pk_valid, 0);
    for (int s = 0; s < FRAME; s++) drive_code(frame_codes[s]);
    for (int p = 0; p < P; p++) begin
      n = 0;
      while (!pk_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      // Counting the accept/handshake cycle as cycle 0, pk_valid is first
      // seen in cycle BIN_NUM+1, i.e. BIN_NUM edges later.
      check({tag, "_latency"}, n, BIN_NUM);
      check({tag, "_pixel"}, pk_pixel, p);
      check({tag, "_bin"}, pk_bin, exp_bin[p]);
      check({tag, "_count"}, pk_count, exp_cnt[p]);
      check({tag, "_hit"}, pk_hit, exp_cnt[p] >= MIN_PEAK);
      check({tag, "_sat_bin"}, s_pk_bin, sat_bin[p]);
      check({tag, "_sat_count"}, s_pk_count, sat_cnt[p]);
      check({tag, "_sat_hit"}, s_pk_hit, sat_cnt[p] >= MIN_PEAK);
      check({tag, "_in_ready_low"}, in_ready, 0);
      stall = (p == 0 && stall0 >= 0) ? stall0 : int'($urandom_range(0, 3));
      repeat (stall) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, pk_valid, 1);
        check({tag, "_hold_pixel"}, pk_pixel, p);
        check({tag, "_hold_bin"}, pk_bin, exp_bin[p]);
        check({tag, "_hold_count"}, pk_count, exp_cnt[p]);
        check({tag, "_hold_in_ready"}, in_ready, 0);
        check({tag, "_hold_frame_done"}, frame_done, 0);
      end
      pk_ready = 1'b1;
      #1;
      check({tag, "_frame_done"}, frame_done, p == P - 1);
      @(posedge clk); #1;
      pk_ready = 1'b0;
      check({tag, "_valid_drop"}, pk_valid, 0);
    end
    check({tag, "_in_ready_after"}, in_ready, 1);
  endtask

  task automatic load_test1();
    for (int s = 0; s < FRAME; s++) frame_codes[s] = ((s / D) % P == 0) ? 108 : 1022;
  endtask

  task automatic load_zero();
    for (int s = 0; s < FRAME; s++) frame_codes[s] = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int k;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    res = 1'b0;
    @(posedge clk); #1;
    check("reset_release_in_ready", in_ready, 1);

    load_test1();
    run_frame("t1", -1);

    for (int s = 0; s < FRAME; s++) begin
      if ((s / D) % P == 0) begin
        k = (s / (P * D)) * D + (s % D);
        frame_codes[s] = (k % 2 == 0) ? 64 : 640;
      end else begin
        frame_codes[s] = 300;
      end
    end
    run_frame("t2_tie", -1);

    load_zero();
    run_frame("t3_zero", -1);

    load_test1();
    run_frame("t4_stall", 5);

    // Partial frame discarded by an asynchronous reset.
    for (int s = 0; s < 5; s++) drive_code(300);
    res = 1'b1;
    #1;
    check_reset_outputs("midres");
    @(posedge clk); #1;
    res = 1'b0;
    @(posedge clk); #1;
    check("midres_in_ready", in_ready, 1);
    load_test1();
    run_frame("res_t1", -1);
    load_zero();
    run_frame("res_zero", -1);

    // Same sequence with a synchronous abort.
    for (int s = 0; s < 5; s++) drive_code(300);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_pk_valid", pk_valid, 0);
    check("clr_in_ready", in_ready, 1);
    load_test1();
    run_frame("clr_t1", -1);
    load_zero();
    run_frame("clr_zero", -1);

    // Random frames: a few bins per pixel so ties and saturation occur.
    for (int f = 0; f < 8; f++) begin
      for (int s = 0; s < FRAME; s++) begin
        if ($urandom_range(0, 3) == 0) frame_codes[s] = 0;
        else frame_codes[s] = int'($urandom_range(0, 3)) * 64 * (1 + (f % 4))
                              + int'($urandom_range(0, 63));
      end
      run_frame("rand", -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_hist_peak_builder
`default_nettype wire
